// File: rtl/ah_ci_pkg.sv
// ah_ci_pkg: shared FSM state codes and CI bundle widths for ah_ci_master and ah_func_instr-style slaves
// Contents: ST_* state constants, CI_DATA_W operand/result width, CI_CNT_W element-count width
package ah_ci_pkg;
    localparam int CI_DATA_W = 32;
    localparam int CI_CNT_W  = 16;
    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_FETCH  = 3'd1;
    localparam logic [2:0] ST_ISSUE  = 3'd2;
    localparam logic [2:0] ST_WAIT   = 3'd3;
    localparam logic [2:0] ST_RESULT = 3'd4;
endpackage

// File: rtl/ah_ci_if.sv
// ah_ci_if: multicycle custom-instruction bundle between one initiator and one CI slave
// Signals: ci_start/ci_clk_en/ci_dataa/ci_datab driven by master; ci_result/ci_done driven by slave
interface ah_ci_if
    import ah_ci_pkg::*;
#(
    parameter int DATA_W = CI_DATA_W
);
    logic              ci_start;
    logic              ci_clk_en;
    logic [DATA_W-1:0] ci_dataa;
    logic [DATA_W-1:0] ci_datab;
    logic [DATA_W-1:0] ci_result;
    logic              ci_done;
    modport master (output ci_start, ci_clk_en, ci_dataa, ci_datab, input ci_result, ci_done);
    modport slave  (input ci_start, ci_clk_en, ci_dataa, ci_datab, output ci_result, ci_done);
endinterface

// File: rtl/ah_ci_timeout.sv
// ah_ci_timeout: loadable down-counter that flags expiry on its last enabled cycle
// Ports: clk, rst_n (async active-low), load/load_val (reload), en (count), expired (final count reached while enabled)
module ah_ci_timeout #(
    parameter int W = 10
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic         en,
    input  logic [W-1:0] load_val,
    output logic         expired
);
    logic [W-1:0] cnt_q, cnt_d;
    // A load value of zero parks the counter at zero, so it can never expire.
    always_comb cnt_d = load ? load_val : (en && cnt_q != '0) ? cnt_q - W'(1) : cnt_q;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    assign expired = en && cnt_q == W'(1);
endmodule

// File: rtl/ah_ci_master.sv
// ah_ci_master: initiator that folds an x stream through a multicycle CI slave, result fed back as datab
// Ports: clk, reset_n (async active-low); cmd_* command in (count, init); x_* operand stream in;
//        ci (ah_ci_if.master) slave bundle; res_* final result out; busy, timeout_err (sticky) status
module ah_ci_master
    import ah_ci_pkg::*;
#(
    parameter int DATA_W  = CI_DATA_W,
    parameter int CNT_W   = CI_CNT_W,
    parameter int TIMEOUT = 1023
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [CNT_W-1:0]  cmd_count,
    input  logic [DATA_W-1:0] cmd_init,
    input  logic              x_valid,
    output logic              x_ready,
    input  logic [DATA_W-1:0] x_data,
    ah_ci_if.master           ci,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [DATA_W-1:0] res_data,
    output logic              busy,
    output logic              timeout_err
);
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    logic [2:0]        state_q, state_d;
    logic [DATA_W-1:0] acc_q, acc_d, dataa_q, dataa_d, datab_q, datab_d;
    logic [CNT_W-1:0]  rem_q, rem_d;
    logic              terr_q, terr_d;
    logic              tmo_expired;
    ah_ci_timeout #(.W(TW)) u_tmo (
        .clk      (clk),
        .rst_n    (reset_n),
        .load     (state_q == ST_ISSUE),
        .en       (state_q == ST_WAIT),
        .load_val (TW'(TIMEOUT)),
        .expired  (tmo_expired)
    );
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        rem_d   = rem_q;
        dataa_d = dataa_q;
        datab_d = datab_q;
        terr_d  = terr_q;
        case (state_q)
            ST_IDLE: if (cmd_valid) begin
                acc_d   = cmd_init;
                rem_d   = cmd_count;
                terr_d  = 1'b0;
                state_d = (cmd_count == '0) ? ST_RESULT : ST_FETCH;
            end
            ST_FETCH: if (x_valid) begin
                dataa_d = x_data;
                datab_d = acc_q;
                state_d = ST_ISSUE;
            end
            ST_ISSUE: state_d = ST_WAIT;
            // A done landing on the expiry cycle still counts; acc keeps the last good result on timeout.
            ST_WAIT: if (ci.ci_done) begin
                acc_d   = ci.ci_result;
                rem_d   = rem_q - CNT_W'(1);
                state_d = (rem_q == CNT_W'(1)) ? ST_RESULT : ST_FETCH;
            end else if (tmo_expired) begin
                terr_d  = 1'b1;
                state_d = ST_RESULT;
            end
            ST_RESULT: if (res_ready) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            state_q <= ST_IDLE;
            acc_q   <= '0;
            rem_q   <= '0;
            dataa_q <= '0;
            datab_q <= '0;
            terr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            rem_q   <= rem_d;
            dataa_q <= dataa_d;
            datab_q <= datab_d;
            terr_q  <= terr_d;
        end
    assign cmd_ready    = state_q == ST_IDLE;
    assign x_ready      = state_q == ST_FETCH;
    assign res_valid    = state_q == ST_RESULT;
    assign busy         = state_q != ST_IDLE;
    assign res_data     = acc_q;
    assign timeout_err  = terr_q;
    assign ci.ci_start  = state_q == ST_ISSUE;
    assign ci.ci_clk_en = 1'b1;
    assign ci.ci_dataa  = dataa_q;
    assign ci.ci_datab  = datab_q;
    // A multicycle slave must never complete in the same cycle it is started.
    a_no_done_in_issue: assert property (@(posedge clk) disable iff (!reset_n) !(state_q == ST_ISSUE && ci.ci_done));
endmodule
